// File: rtl/fei4_cmd_pkg.sv
// FE-I4 command codes, field lengths and decoder state encoding.
// Latency: n/a (constants only); backpressure: n/a.
package fei4_cmd_pkg;

    localparam int CNT_W = 10;

    localparam logic [4:0] HDR_LV1  = 5'b11101;
    localparam logic [4:0] HDR_FAST = 5'b10110;

    localparam logic [3:0] FAST_BCR  = 4'b0001;
    localparam logic [3:0] FAST_ECR  = 4'b0010;
    localparam logic [3:0] FAST_CAL  = 4'b0100;
    localparam logic [3:0] FAST_SLOW = 4'b1000;

    localparam logic [3:0] ST_RDREG   = 4'b0001;
    localparam logic [3:0] ST_WRREG   = 4'b0010;
    localparam logic [3:0] ST_WRFE    = 4'b0100;
    localparam logic [3:0] ST_GRST    = 4'b1000;
    localparam logic [3:0] ST_GPULSE  = 4'b1001;
    localparam logic [3:0] ST_RUNMODE = 4'b1010;

    localparam logic [5:0] RUNMODE_RUN  = 6'b111000;
    localparam logic [5:0] RUNMODE_CONF = 6'b000111;

    localparam logic [CNT_W-1:0] LEN_HDR    = 10'd5;
    localparam logic [CNT_W-1:0] LEN_FAST   = 10'd4;
    localparam logic [CNT_W-1:0] LEN_STYPE  = 10'd4;
    localparam logic [CNT_W-1:0] LEN_SID    = 10'd4;
    localparam logic [CNT_W-1:0] LEN_SFIELD = 10'd6;
    localparam logic [CNT_W-1:0] LEN_SDATA  = 10'd16;

    typedef enum logic [2:0] {
        IDLE, HDR, FAST, STYPE, SID, SFIELD, SDATA, FEDATA
    } state_t;

    function automatic logic stype_legal(input logic [3:0] t);
        return (t == ST_RDREG) || (t == ST_WRREG) || (t == ST_WRFE) ||
               (t == ST_GRST) || (t == ST_GPULSE) || (t == ST_RUNMODE);
    endfunction

endpackage

// File: rtl/fei4_cmd_shift.sv
// Serial-in shift register with field bit counter; last flags the final bit of a field.
// Latency: field/last are combinational on the current bit; backpressure: none.
module fei4_cmd_shift
    import fei4_cmd_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic [15:0]      field,
    output logic             last
);

    localparam logic [CNT_W-1:0] ONE = 10'd1;

    logic [14:0]      sreg;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt + ONE;
    // Field includes the bit being sampled now so the FSM decides on the same edge.
    assign field   = {sreg, din};
    assign last    = en && (cnt_inc == term);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (en) begin
            sreg <= field[14:0];
            cnt  <= last ? '0 : cnt_inc;
        end
    end

endmodule

// File: rtl/fei4_cmd_decoder.sv
// FE-I4 serial command decoder: fast/trigger/slow commands to one-cycle strobes and fields.
// Latency: outputs one cycle after the edge sampling the last bit; backpressure: none.
module fei4_cmd_decoder
    import fei4_cmd_pkg::*;
#(
    parameter logic [3:0] CHIP_ID = 4'b0000,
    parameter int         FE_BITS = 672
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CMD_DATA,
    output logic        LV1,
    output logic        BCR,
    output logic        ECR,
    output logic        CAL,
    output logic        GLOBAL_RESET,
    output logic        GLOBAL_PULSE,
    output logic [5:0]  PULSE_WIDTH,
    output logic        RUN_MODE,
    output logic        REG_RD,
    output logic        REG_WR,
    output logic [5:0]  REG_ADDR,
    output logic [15:0] REG_DATA,
    output logic        FE_SHIFT,
    output logic        FE_BIT,
    output logic        FE_DONE,
    output logic        CMD_ERR
);

    state_t           state, state_n;
    logic [3:0]       stype, stype_n;
    logic             match, match_n;
    logic [5:0]       wr_addr, wr_addr_n;
    logic             en, last, id_match;
    logic [15:0]      field;
    logic [CNT_W-1:0] term;

    logic lv1_n, bcr_n, ecr_n, cal_n, grst_n, gp_n, rd_n, wr_n;
    logic fe_shift_n, fe_bit_n, fe_done_n, err_n, run_n;
    logic [5:0]  addr_n, width_n;
    logic [15:0] data_n;

    assign en       = (state != IDLE) || CMD_DATA;
    assign id_match = (field[3:0] == CHIP_ID) || field[3];

    always_comb begin
        term = LEN_HDR;
        case (state)
            FAST:          term = LEN_FAST;
            STYPE:         term = LEN_STYPE;
            SID:           term = LEN_SID;
            SFIELD:        term = LEN_SFIELD;
            SDATA:         term = LEN_SDATA;
            FEDATA:        term = CNT_W'(FE_BITS);
            default:       term = LEN_HDR;
        endcase
    end

    fei4_cmd_shift u_shift (
        .clk   (CLK),
        .rst_n (RST_N),
        .din   (CMD_DATA),
        .en    (en),
        .term  (term),
        .field (field),
        .last  (last)
    );

    always_comb begin
        state_n = state;  stype_n = stype;  match_n = match;  wr_addr_n = wr_addr;
        addr_n  = REG_ADDR;  data_n = REG_DATA;  width_n = PULSE_WIDTH;  run_n = RUN_MODE;
        lv1_n = 1'b0;  bcr_n = 1'b0;  ecr_n = 1'b0;  cal_n = 1'b0;
        grst_n = 1'b0; gp_n = 1'b0;   rd_n = 1'b0;   wr_n = 1'b0;
        fe_shift_n = 1'b0;  fe_bit_n = 1'b0;  fe_done_n = 1'b0;  err_n = 1'b0;
        case (state)
            IDLE: if (CMD_DATA) state_n = HDR;
            HDR: if (last) begin
                state_n = IDLE;
                if (field[4:0] == HDR_LV1)       lv1_n   = 1'b1;
                else if (field[4:0] == HDR_FAST) state_n = FAST;
                else                             err_n   = 1'b1;
            end
            FAST: if (last) begin
                state_n = IDLE;
                case (field[3:0])
                    FAST_BCR:  bcr_n   = 1'b1;
                    FAST_ECR:  ecr_n   = 1'b1;
                    FAST_CAL:  cal_n   = 1'b1;
                    FAST_SLOW: state_n = STYPE;
                    default:   err_n   = 1'b1;
                endcase
            end
            STYPE: if (last) begin
                if (stype_legal(field[3:0])) begin
                    stype_n = field[3:0];
                    state_n = SID;
                end else begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end
            end
            SID: if (last) begin
                match_n = id_match;
                if (stype == ST_GRST) begin
                    grst_n  = id_match;
                    state_n = IDLE;
                end else begin
                    state_n = SFIELD;
                end
            end
            // A mismatched chip still walks the full command, it just stays silent.
            SFIELD: if (last) begin
                state_n = IDLE;
                case (stype)
                    ST_RDREG: if (match) begin
                        rd_n   = 1'b1;
                        addr_n = field[5:0];
                    end
                    ST_GPULSE: if (match) begin
                        gp_n    = 1'b1;
                        width_n = field[5:0];
                    end
                    ST_RUNMODE: if (match) begin
                        if (field[5:0] == RUNMODE_RUN)       run_n = 1'b1;
                        else if (field[5:0] == RUNMODE_CONF) run_n = 1'b0;
                        else                                 err_n = 1'b1;
                    end
                    ST_WRREG: begin
                        wr_addr_n = field[5:0];
                        state_n   = SDATA;
                    end
                    ST_WRFE: state_n = FEDATA;
                    default: ;
                endcase
            end
            SDATA: if (last) begin
                state_n = IDLE;
                if (match) begin
                    wr_n   = 1'b1;
                    addr_n = wr_addr;
                    data_n = field;
                end
            end
            FEDATA: begin
                fe_shift_n = match;
                fe_bit_n   = match & CMD_DATA;
                if (last) begin
                    fe_done_n = match;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;  stype <= '0;  match <= 1'b0;  wr_addr <= '0;
            LV1 <= 1'b0;  BCR <= 1'b0;  ECR <= 1'b0;  CAL <= 1'b0;
            GLOBAL_RESET <= 1'b0;  GLOBAL_PULSE <= 1'b0;  PULSE_WIDTH <= '0;
            RUN_MODE <= 1'b0;  REG_RD <= 1'b0;  REG_WR <= 1'b0;
            REG_ADDR <= '0;  REG_DATA <= '0;
            FE_SHIFT <= 1'b0;  FE_BIT <= 1'b0;  FE_DONE <= 1'b0;  CMD_ERR <= 1'b0;
        end else begin
            state <= state_n;  stype <= stype_n;  match <= match_n;  wr_addr <= wr_addr_n;
            LV1 <= lv1_n;  BCR <= bcr_n;  ECR <= ecr_n;  CAL <= cal_n;
            GLOBAL_RESET <= grst_n;  GLOBAL_PULSE <= gp_n;  PULSE_WIDTH <= width_n;
            RUN_MODE <= run_n;  REG_RD <= rd_n;  REG_WR <= wr_n;
            REG_ADDR <= addr_n;  REG_DATA <= data_n;
            FE_SHIFT <= fe_shift_n;  FE_BIT <= fe_bit_n;  FE_DONE <= fe_done_n;  CMD_ERR <= err_n;
        end
    end

endmodule
